// File: rtl/alu_result_stage.sv
// Registered result stage behind the ALU: a 2-entry FIFO skid buffer that stores
// result, opcode and push-time flags, plus a saturating overflow event counter.
module alu_result_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_result,
  input  logic [4:0]            in_opcode,
  input  logic                  in_overflow,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic [4:0]            out_opcode,
  output logic                  out_zero,
  output logic                  out_neg,
  output logic                  out_ovf,
  output logic [CNT_WIDTH-1:0]  ovf_count,
  input  logic                  ovf_clear
);

  typedef enum logic [4:0] {
    OP_ADD = 5'b00000,
    OP_SUB = 5'b00001,
    OP_AND = 5'b00010,
    OP_OR  = 5'b00011,
    OP_SLL = 5'b00100,
    OP_SRA = 5'b00101
  } opcode_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] result;
    logic [4:0]            opcode;
    logic                  zero;
    logic                  neg;
    logic                  ovf;
  } entry_t;

  entry_t                 mem [2];
  logic                   rd_ptr;
  logic                   wr_ptr;
  logic [1:0]             count;
  logic [CNT_WIDTH-1:0]   ovf_cnt;
  logic                   push;
  logic                   pop;
  entry_t                 new_entry;
  entry_t                 head;

  assign in_ready  = (count < 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready && !reset;
  assign pop       = out_valid && out_ready && !reset;

  // Overflow is only meaningful for the adder/subtractor; everything else stores 0.
  always_comb begin
    new_entry        = '0;
    new_entry.result = in_result;
    new_entry.opcode = in_opcode;
    new_entry.zero   = (in_result == '0);
    new_entry.neg    = in_result[DATA_WIDTH-1];
    new_entry.ovf    = in_overflow &&
                       ((in_opcode == OP_ADD) || (in_opcode == OP_SUB));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
      // NOTE: storage is cleared too, so a stale entry can never reappear on the outputs.
      for (int i = 0; i < 2; i++) mem[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments let every register see pre-edge values of the others.
      if (push) begin
        mem[wr_ptr] <= new_entry;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Clear wins over an increment landing in the same cycle.
  always_ff @(posedge clock) begin
    if (reset || ovf_clear) begin
      ovf_cnt <= '0;
    end else if (push && new_entry.ovf && !(&ovf_cnt)) begin
      ovf_cnt <= ovf_cnt + 1'b1;
    end
  end

  assign head       = mem[rd_ptr];
  assign out_result = out_valid ? head.result : '0;
  assign out_opcode = out_valid ? head.opcode : 5'b0;
  assign out_zero   = out_valid && head.zero;
  assign out_neg    = out_valid && head.neg;
  assign out_ovf    = out_valid && head.ovf;
  assign ovf_count  = ovf_cnt;

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed scenarios plus random traffic,
// compared cycle by cycle against a queue-based model of the FIFO behaviour.
module tb_alu_result_stage;

  localparam int DW = 32;
  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_result;
  logic [4:0]    in_opcode;
  logic          in_overflow;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_result;
  logic [4:0]    out_opcode;
  logic          out_zero;
  logic          out_neg;
  logic          out_ovf;
  logic [CW-1:0] ovf_count;
  logic          ovf_clear;

  int compared   = 0;
  int mismatched = 0;

  always #5 clock = ~clock;

  alu_result_stage #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_opcode(in_opcode), .in_overflow(in_overflow),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_opcode(out_opcode),
    .out_zero(out_zero), .out_neg(out_neg), .out_ovf(out_ovf),
    .ovf_count(ovf_count), .ovf_clear(ovf_clear)
  );

  // Reference model: a plain queue of accepted entries plus an overflow tally.
  typedef struct {
    logic [DW-1:0] result;
    logic [4:0]    opcode;
    logic          ovf;
  } ent_t;

  ent_t          mq[$];
  logic [CW-1:0] m_ovf = '0;

  localparam int VW = 1 + DW + 5 + 3 + 1 + CW;
  logic [VW-1:0] obs_vec;
  assign obs_vec = {out_valid, out_result, out_opcode, out_zero, out_neg, out_ovf,
                    in_ready, ovf_count};

  function automatic logic [VW-1:0] exp_vec();
    ent_t e;
    logic rdy;
    rdy = (mq.size() < 2);
    if (mq.size() == 0) return {1'b0, {DW{1'b0}}, 5'b0, 3'b0, rdy, m_ovf};
    e = mq[0];
    return {1'b1, e.result, e.opcode, (e.result == '0), e.result[DW-1], e.ovf, rdy, m_ovf};
  endfunction

  // Advance one clock; the model applies the transfer rules to the pre-edge inputs.
  task automatic tick();
    bit   push, pop;
    ent_t e;
    push     = in_valid && (mq.size() < 2) && !reset;
    pop      = (mq.size() != 0) && out_ready && !reset;
    e.result = in_result;
    e.opcode = in_opcode;
    e.ovf    = in_overflow && (in_opcode == 5'd0 || in_opcode == 5'd1);
    @(posedge clock);
    #1;
    if (reset) begin
      mq.delete();
      m_ovf = '0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(e);
      if (ovf_clear) m_ovf = '0;
      else if (push && e.ovf && m_ovf != {CW{1'b1}}) m_ovf = m_ovf + 1'b1;
    end
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_result = '0; in_opcode = '0; in_overflow = 0;
    out_ready = 0; ovf_clear = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    tick();
    tick();
    compared++;
    if (obs_vec !== exp_vec()) begin
      mismatched++;
      $display("FAIL reset_state: got %h want %h", obs_vec, exp_vec());
    end
    compared++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_handshake: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
    reset = 0;
  endtask

  task automatic test_single_sra();
    do_reset();
    out_ready = 1;
    in_valid = 1; in_opcode = 5'b00101; in_result = 32'hF000_0000; in_overflow = 0;
    tick();
    in_valid = 0;
    compared++;
    if (out_valid !== 1 || out_result !== 32'hF000_0000 || out_neg !== 1 ||
        out_zero !== 0 || out_ovf !== 0 || out_opcode !== 5'b00101) begin
      mismatched++;
      $display("FAIL sra_single: got v=%b r=%h op=%b z=%b n=%b o=%b want 1 f0000000 00101 0 1 0",
               out_valid, out_result, out_opcode, out_zero, out_neg, out_ovf);
    end
    tick();
    compared++;
    if (out_valid !== 1'b0 || obs_vec !== exp_vec()) begin
      mismatched++;
      $display("FAIL sra_drain: got %h want %h", obs_vec, exp_vec());
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 0;
    in_valid = 1; in_opcode = 5'b00000; in_result = 32'h7FFF_FFFF; in_overflow = 1;
    tick();
    in_opcode = 5'b00001; in_result = 32'h0; in_overflow = 0;
    tick();
    compared++;
    if (in_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL bp_full: in_ready=%b want 0", in_ready);
    end
    in_opcode = 5'b00011; in_result = 32'h1234_5678; in_overflow = 0;
    tick();
    in_valid = 0;
    compared++;
    if (out_result !== 32'h7FFF_FFFF || out_ovf !== 1 || ovf_count !== 4'd1 ||
        obs_vec !== exp_vec()) begin
      mismatched++;
      $display("FAIL bp_hold_add: got %h want %h", obs_vec, exp_vec());
    end
    out_ready = 1;
    tick();
    compared++;
    if (out_valid !== 1 || out_opcode !== 5'b00001 || out_zero !== 1 ||
        obs_vec !== exp_vec()) begin
      mismatched++;
      $display("FAIL bp_sub_next: got %h want %h", obs_vec, exp_vec());
    end
    tick();
    compared++;
    if (out_valid !== 1'b0 || obs_vec !== exp_vec()) begin
      mismatched++;
      $display("FAIL bp_third_ignored: got %h want %h", obs_vec, exp_vec());
    end
  endtask

  task automatic test_stream();
    do_reset();
    out_ready = 1;
    in_valid = 1; in_opcode = 5'b00010; in_overflow = 0;
    for (int i = 0; i < 8; i++) begin
      in_result = DW'(i);
      tick();
      compared++;
      if (out_valid !== 1 || out_result !== DW'(i) || in_ready !== 1 ||
          obs_vec !== exp_vec()) begin
        mismatched++;
        $display("FAIL stream_%0d: got %h want %h", i, obs_vec, exp_vec());
      end
    end
    in_valid = 0;
    tick();
    compared++;
    if (out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL stream_end: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_sll_ovf();
    do_reset();
    out_ready = 1;
    in_valid = 1; in_opcode = 5'b00100; in_result = 32'h8000_0000; in_overflow = 1;
    tick();
    in_valid = 0;
    compared++;
    if (out_valid !== 1 || out_ovf !== 0 || ovf_count !== 4'd0 || out_neg !== 1) begin
      mismatched++;
      $display("FAIL sll_ovf: got v=%b ovf=%b cnt=%0d neg=%b want 1 0 0 1",
               out_valid, out_ovf, ovf_count, out_neg);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    out_ready = 1;
    in_valid = 1; in_opcode = 5'b00000; in_result = 32'h8000_0001; in_overflow = 1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i >= 15) begin
        compared++;
        if (ovf_count !== 4'hF || obs_vec !== exp_vec()) begin
          mismatched++;
          $display("FAIL sat_%0d: ovf_count=%h want f", i, ovf_count);
        end
      end
    end
    ovf_clear = 1;
    tick();
    ovf_clear = 0;
    in_valid = 0;
    compared++;
    if (ovf_count !== 4'h0 || out_ovf !== 1) begin
      mismatched++;
      $display("FAIL sat_clear_priority: ovf_count=%h out_ovf=%b want 0 1", ovf_count, out_ovf);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 0;
    in_valid = 1; in_opcode = 5'b00000; in_result = 32'hDEAD_BEEF; in_overflow = 1;
    tick();
    in_result = 32'h0000_0042;
    tick();
    in_valid = 0;
    reset = 1;
    tick();
    reset = 0;
    compared++;
    if (out_valid !== 0 || out_result !== '0 || out_opcode !== 5'b0 || out_neg !== 0 ||
        out_ovf !== 0 || ovf_count !== 4'd0 || obs_vec !== exp_vec()) begin
      mismatched++;
      $display("FAIL reset_mid: got %h want %h", obs_vec, exp_vec());
    end
    in_valid = 1; in_opcode = 5'b00011; in_result = 32'h0000_00A5; in_overflow = 0;
    tick();
    in_valid = 0;
    compared++;
    if (out_valid !== 1 || out_result !== 32'h0000_00A5 || obs_vec !== exp_vec()) begin
      mismatched++;
      $display("FAIL reset_mid_repush: got %h want %h", obs_vec, exp_vec());
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      out_ready   = ($urandom_range(0, 2) != 0);
      in_opcode   = 5'($urandom_range(0, 7));
      in_result   = ($urandom_range(0, 7) == 0) ? '0 : $urandom();
      in_overflow = $urandom_range(0, 1) != 0;
      ovf_clear   = ($urandom_range(0, 31) == 0);
      reset       = ($urandom_range(0, 63) == 0);
      tick();
      compared++;
      if (obs_vec !== exp_vec()) begin
        mismatched++;
        $display("FAIL random_%0d: got %h want %h", i, obs_vec, exp_vec());
      end
    end
    reset = 0;
    idle_inputs();
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    test_reset();
    test_single_sra();
    test_backpressure();
    test_stream();
    test_sll_ovf();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Registered output stage directly downstream of the ALU datapath (adder, logic ops, SLL, SRA).
- Captures the ALU result and opcode in a 2-entry FIFO skid buffer.
- Derives status flags and drives the valid/ready handshake to the writeback/bypass consumer.
- Keeps a saturating count of accepted results that signalled arithmetic overflow.

Parameters:
DATA_WIDTH, 32, width of ALU result and output data
CNT_WIDTH, 16, width of overflow event counter

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  ALU result valid this cycle
in_ready  output  1  stage can accept a result this cycle
in_result  input  DATA_WIDTH  ALU result (any op, incl. shifter output)
in_opcode  input  5  ALU opcode: 00000 ADD, 00001 SUB, 00010 AND, 00011 OR, 00100 SLL, 00101 SRA; others reserved
in_overflow  input  1  raw overflow from adder/subtractor
out_valid  output  1  head entry valid
out_ready  input  1  consumer accepts head entry
out_result  output  DATA_WIDTH  head result
out_opcode  output  5  head opcode
out_zero  output  1  head result == 0
out_neg  output  1  head result MSB
out_ovf  output  1  qualified overflow of head entry
ovf_count  output  CNT_WIDTH  accepted overflow events, saturating
ovf_clear  input  1  clears ovf_count

Behaviour:
- Storage: 2 entries, each {result, opcode, zero, neg, ovf}; read pointer, write pointer, 2-bit occupancy count (0..2).
- Flags computed at push time from inputs:
  - zero = (in_result == 0).
  - neg = in_result[DATA_WIDTH-1].
  - ovf = in_overflow only when opcode is ADD or SUB, else 0. Reserved opcodes are stored unchanged with ovf = 0.
- in_ready = (count < 2), combinational from the count register, not from out_ready.
- Push: in_valid && in_ready && !reset. Pop: out_valid && out_ready && !reset.
- out_valid = (count != 0).
- out_* show the head entry. All out_* data/flag outputs are forced to 0 while out_valid = 0.
- Latency: a push into an empty stage gives out_valid = 1 on the next cycle. There is no combinational in-to-out path.
- Count update: push only -> +1. Pop only -> -1. Push and pop together -> unchanged; head advances, new entry written at tail.
- Full (count = 2): in_ready = 0. An in_valid asserted while full is ignored; the upstream must hold it.
- Empty (count = 0): out_ready is ignored.
- Pointer wrap: 1-bit pointers wrap 1 -> 0.
- Ordering is strictly FIFO. An entry is never dropped or duplicated.
- Output stability: while out_valid = 1 and out_ready = 0, out_* hold constant.
- ovf_count:
  - On a push with qualified ovf = 1, increments by 1.
  - Saturates at all-ones.
  - ovf_clear = 1 sets it to 0, and takes priority over an increment in the same cycle.
- Reset:
  - count, pointers, ovf_count and storage all clear to 0.
  - out_valid = 0 and all out_* = 0 on the cycle after reset is sampled high.
  - in_ready = 1 once count = 0, but pushes and pops are inhibited while reset = 1.
  - Reset mid-transfer discards buffered entries without emitting them.

Test Plan:
- Reset then single push of SRA (00101), result 0xF0000000, out_ready = 1 -> one cycle later out_valid = 1, out_result = 0xF0000000, out_neg = 1, out_zero = 0, out_ovf = 0; out_valid = 0 the following cycle.
- out_ready held 0, push ADD 0x7FFFFFFF with ovf = 1, then SUB 0x00000000 with ovf = 0 -> in_ready falls to 0 after the second push; a third in_valid is ignored. Release out_ready -> outputs the ADD entry (ovf = 1, ovf_count = 1), then the SUB entry (zero = 1) in order.
- Continuous in_valid = 1 and out_ready = 1 stream of 8 results 0..7 -> one result per cycle, no bubbles after first, exact order, count never exceeds 1.
- SLL (00100) with in_overflow = 1 -> out_ovf = 0 and ovf_count unchanged.
- Preload ovf_count to all-ones via repeated ADD overflows (CNT_WIDTH = 4 build, 16 pushes), then one more -> stays 0xF. Assert ovf_clear together with an overflow push -> count = 0.
- Fill 2 entries, then assert reset for one cycle -> out_valid = 0, out_* = 0, ovf_count = 0; the next push behaves as from empty.
